// File: rtl/ir_key_event.sv
// NEC frame checker: validates inverse bytes, suppresses auto-repeat of a held key,
// and queues bit-order-corrected key events behind a valid/ready FIFO.
module ir_key_event #(
    parameter int HOLD_TIMEOUT = 12_000_000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        new_code_in,
    output logic [7:0]  key_out,
    output logic [7:0]  addr_out,
    output logic        key_valid_out,
    input  logic        key_ready_in,
    output logic        key_held_out,
    output logic        error_pulse_out,
    output logic [1:0]  error_code_out,
    output logic [1:0]  state_out
);

    localparam int TW = $clog2(HOLD_TIMEOUT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] TMAX = TW'(HOLD_TIMEOUT);
    localparam logic [TW-1:0] TONE = TW'(1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, PUSH = 2'd2, REJECT = 2'd3} state_t;

    state_t state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [15:0] last_key_q, last_key_d;
    logic        last_valid_q, last_valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        held_q, held_d;
    logic        err_pulse_q, err_pulse_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [FIFO_DEPTH-1:0][15:0] mem_q, mem_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0] head_q, head_d;

    logic addr_ok, cmd_ok, is_repeat;
    logic load_code, rpt_hit, do_push, do_reject;
    logic pop, full, push_ok, overflow;
    logic [15:0] entry;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign addr_ok   = (code_q[23:16] == ~code_q[31:24]);
    assign cmd_ok    = (code_q[7:0] == ~code_q[15:8]);
    assign is_repeat = last_valid_q && ({code_q[31:24], code_q[15:8]} == last_key_q)
                       && (timer_q < TMAX);
    assign entry     = {rev8(code_q[31:24]), rev8(code_q[15:8])};

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_code_in) state_d = CHECK;
            CHECK: begin
                if (!addr_ok || !cmd_ok) state_d = REJECT;
                else if (is_repeat)      state_d = IDLE;
                else                     state_d = PUSH;
            end
            PUSH:    state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_code = 1'b0;
        rpt_hit   = 1'b0;
        do_push   = 1'b0;
        do_reject = 1'b0;
        state_out = state_q;
        case (state_q)
            IDLE:    load_code = new_code_in;
            CHECK:   rpt_hit = addr_ok && cmd_ok && is_repeat;
            PUSH:    do_push = 1'b1;
            REJECT:  do_reject = 1'b1;
            default: ;
        endcase
    end

    // Hold tracking, FIFO and error datapath
    always_comb begin
        code_d       = load_code ? code_in : code_q;
        timer_d      = timer_q;
        last_valid_d = last_valid_q;
        last_key_d   = last_key_q;
        held_d       = held_q;
        if (last_valid_q && timer_q != TMAX) begin
            timer_d = timer_q + TONE;
            if (timer_d == TMAX) begin
                last_valid_d = 1'b0;
                held_d       = 1'b0;
            end
        end
        if (rpt_hit) begin
            timer_d      = '0;
            held_d       = 1'b1;
            last_valid_d = 1'b1;
        end
        if (do_push) begin
            last_key_d   = {code_q[31:24], code_q[15:8]};
            last_valid_d = 1'b1;
            timer_d      = '0;
            held_d       = 1'b0;
        end

        pop      = (count_q != '0) && key_ready_in;
        full     = (count_q == CFULL);
        push_ok  = do_push && (!full || pop);
        overflow = do_push && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + PONE;
            count_d         = count_d + CONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PONE;
            count_d  = count_d - CONE;
        end
        head_d = head_q;
        if (count_d != '0) head_d = mem_d[rd_ptr_d];

        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        if (do_reject) begin
            err_pulse_d = 1'b1;
            err_code_d  = addr_ok ? 2'd2 : 2'd1;
        end
        if (overflow) begin
            err_pulse_d = 1'b1;
            err_code_d  = 2'd3;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            code_q       <= '0;
            timer_q      <= '0;
            last_valid_q <= 1'b0;
            last_key_q   <= '0;
            held_q       <= 1'b0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            code_q       <= code_d;
            timer_q      <= timer_d;
            last_valid_q <= last_valid_d;
            last_key_q   <= last_key_d;
            held_q       <= held_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

    assign key_out         = head_q[7:0];
    assign addr_out        = head_q[15:8];
    assign key_valid_out   = (count_q != '0);
    assign key_held_out    = held_q;
    assign error_pulse_out = err_pulse_q;
    assign error_code_out  = err_code_q;

endmodule

// File: doc/ir_key_event.md
# ir_key_event

Downstream consumer of the IR decoder's 32-bit NEC frame output. Checks each frame's address/command inverse bytes and converts valid frames to bit-order-corrected key press events. Suppresses auto-repeat of a held key using a hold timer. Buffers events in a small FIFO behind a valid/ready handshake for the game/control logic.

## Interface
- HOLD_TIMEOUT, 12_000_000: cycles (120 ms at 100 MHz) after the last frame in which an identical frame counts as a hold, not a new press
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2)
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous, active-high reset
- code_in  input  32  decoder frame, first-received bit in bit 31
- new_code_in  input  1  single-cycle strobe; code_in valid this cycle
- key_out  output  8  NEC command of FIFO head (LSB-first corrected)
- addr_out  output  8  NEC address of FIFO head (LSB-first corrected)
- key_valid_out  output  1  FIFO non-empty
- key_ready_in  input  1  consumer pops head when key_valid_out & key_ready_in
- key_held_out  output  1  level; current key is being held
- error_pulse_out  output  1  single-cycle error strobe
- error_code_out  output  2  last error: 0 none, 1 address check, 2 command check, 3 FIFO overflow
- state_out  output  2  FSM state (debug)

## Operation
- Byte split of code_in: A=[31:24], nA=[23:16], C=[15:8], nC=[7:0]. Address valid iff nA == ~A; command valid iff nC == ~C.
- addr_out/key_out = bit-reverse(A)/bit-reverse(C), giving the on-air LSB-first value.
- FSM states: IDLE(0), CHECK(1), PUSH(2), REJECT(3).
- IDLE: on new_code_in, register code_in, go to CHECK. new_code_in outside IDLE is ignored.
- CHECK:
  - address fail → REJECT, code 1. Address fail has priority over command fail.
  - command fail → REJECT, code 2.
  - valid, last_valid set, {A,C} == last {A,C}, and hold timer < HOLD_TIMEOUT → repeat: set key_held_out=1, clear timer, return to IDLE, no push.
  - any other valid frame → PUSH.
- PUSH: store {A,C} as last and set last_valid. Clear timer and key_held_out. Write the FIFO entry. If the FIFO is full with no pop this cycle: drop the entry, set code 3, pulse error. Return to IDLE.
- REJECT: pulse error_pulse_out, latch error_code_out, return to IDLE. last key, timer and key_held_out unchanged.
- Hold timer:
  - increments every cycle while last_valid, saturating at HOLD_TIMEOUT.
  - on reaching HOLD_TIMEOUT: key_held_out←0, last_valid←0.
  - timer == HOLD_TIMEOUT in the CHECK cycle → frame is a new press.
- FIFO: circular, registered head outputs. Push and pop in the same cycle are both honoured, including when full.
- error_code_out holds until the next error or reset.

## Timing
- Reset values: key_out=0, addr_out=0, key_valid_out=0, key_held_out=0, error_pulse_out=0, error_code_out=0, state_out=0, FIFO empty, timer=0, last_valid=0.
- new_code_in sampled in cycle N (IDLE): CHECK in N+1, PUSH/REJECT in N+2. Back in IDLE at N+3 (N+2 on the repeat path).
- key_valid_out high from N+3 when the FIFO was empty; key_out/addr_out valid the same cycle.
- error_pulse_out high for exactly cycle N+3.
- key_held_out rises at N+2 for a repeat.
- Pop is a registered update: the next head (or key_valid_out=0) appears the cycle after a handshake.
- key_out/addr_out are stable while key_valid_out=1 and no pop occurs.
- Reset mid-operation: all state returns to reset values next cycle; any in-flight frame is discarded.
- Throughput: one frame per 3 cycles (decoder frames are ≥50 ms apart).

## Test plan
- Valid press: code_in=0x00FFA25D strobe, key_ready_in=0 → at N+3 key_valid_out=1, key_out=0x45, addr_out=0x00, key_held_out=0, no error.
- Bad frames:
  - 0x00FEA25D → error_pulse_out at N+3, error_code_out=1, FIFO empty.
  - 0x00FFA25C → error_code_out=2.
- Hold:
  - repeat 0x00FFA25D every 1_000_000 cycles ×5 → one FIFO entry only, key_held_out=1 after 2nd frame.
  - stop → key_held_out=0 exactly HOLD_TIMEOUT cycles after the last frame.
  - same frame after timeout → new entry.
- Key change: 0x00FFA25D then 0x00FF629D within timeout → two entries, key_out 0x45 then 0x46, key_held_out=0.
- Overflow and simultaneous pop:
  - 5 distinct valid frames with key_ready_in=0 → 4 entries; 5th dropped with error_code_out=3.
  - repeat with key_ready_in=1 during the 5th PUSH → no error, 4 entries remain, order preserved.
- Reset: assert rst_in in CHECK cycle → all outputs 0 next cycle, no event or error afterward.
